// File: rtl/hls_ctrl_perf_monitor.sv
// hls_ctrl_perf_monitor: per-channel ap_ctrl_hs/ap_ctrl_chain profiling counters.
// Define PERF_MON_STALL_EN to build the DONE_WAIT state and the stall counters.
module hls_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 3,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy_any
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    DONE_WAIT = 2'd2
  } st_t;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MAXV = '1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == MAXV) ? v : v + cnt_t'(1);
  endfunction

  st_t  st_q   [NUM_CH];
  st_t  st_n   [NUM_CH];
  cnt_t tmr_q  [NUM_CH];
  cnt_t tmr_n  [NUM_CH];
  cnt_t lat    [NUM_CH];
  cnt_t txn_q  [NUM_CH];
  cnt_t busy_q [NUM_CH];
  cnt_t last_q [NUM_CH];
  cnt_t min_q  [NUM_CH];
  cnt_t max_q  [NUM_CH];
  cnt_t ovl_q  [NUM_CH];

  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_n;
  logic [NUM_CH-1:0] rdy_q;
  logic [NUM_CH-1:0] rdy_n;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] fin;
  logic [NUM_CH-1:0] ovl_inc;
  logic [NUM_CH-1:0] hold;
  logic              any_n;
  cnt_t              rd_mux;

`ifdef PERF_MON_STALL_EN
  cnt_t stall_q [NUM_CH];

  assign hold = ~ch_continue;
`else
  logic unused_cont;

  assign hold        = '0;
  assign unused_cont = ^ch_continue;
`endif

  // pend: a re-start accepted behind the oldest in-flight transaction
  always_comb begin
    any_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_n[c]    = st_q[c];
      tmr_n[c]   = tmr_q[c];
      pend_n[c]  = pend_q[c];
      rdy_n[c]   = 1'b0;
      acc[c]     = 1'b0;
      fin[c]     = 1'b0;
      ovl_inc[c] = 1'b0;
      lat[c]     = sat_inc(tmr_q[c]);
      unique case (st_q[c])
        IDLE: begin
          acc[c] = ch_start[c];
          if (ch_start[c] && ch_done[c]) begin
            fin[c]  = 1'b1;
            lat[c]  = cnt_t'(1);
            st_n[c] = hold[c] ? DONE_WAIT : IDLE;
          end else if (ch_start[c]) begin
            st_n[c]  = ACTIVE;
            tmr_n[c] = cnt_t'(1);
            rdy_n[c] = ch_ready[c];
          end
        end
        ACTIVE: begin
          if (ch_done[c] && !hold[c]) begin
            acc[c]     = ch_start[c];
            fin[c]     = 1'b1;
            ovl_inc[c] = ch_start[c] & pend_q[c];
            pend_n[c]  = ch_start[c] & pend_q[c];
            st_n[c]    = (ch_start[c] | pend_q[c]) ? ACTIVE : IDLE;
            tmr_n[c]   = (ch_start[c] | pend_q[c]) ? cnt_t'(1) : '0;
            rdy_n[c]   = ch_ready[c] & (ch_start[c] | pend_q[c]);
          end else begin
            acc[c]     = ch_start[c] & rdy_q[c];
            ovl_inc[c] = acc[c];
            pend_n[c]  = pend_q[c] | acc[c];
            if (ch_done[c]) begin
              fin[c]   = 1'b1;
              st_n[c]  = DONE_WAIT;
              tmr_n[c] = (pend_q[c] | acc[c]) ? cnt_t'(1) : '0;
            end else begin
              tmr_n[c] = sat_inc(tmr_q[c]);
              rdy_n[c] = (rdy_q[c] & ~acc[c]) | ch_ready[c];
            end
          end
        end
        DONE_WAIT: begin
          if (pend_q[c]) tmr_n[c] = sat_inc(tmr_q[c]);
          if (!hold[c]) begin
            st_n[c]   = pend_q[c] ? ACTIVE : IDLE;
            pend_n[c] = 1'b0;
          end
        end
        default: st_n[c] = IDLE;
      endcase
      any_n = any_n | (st_n[c] != IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= IDLE;
        tmr_q[c]  <= '0;
        txn_q[c]  <= '0;
        busy_q[c] <= '0;
        last_q[c] <= '0;
        min_q[c]  <= MAXV;
        max_q[c]  <= '0;
        ovl_q[c]  <= '0;
      end
      pend_q   <= '0;
      rdy_q    <= '0;
      busy_any <= 1'b0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= IDLE;
        tmr_q[c]  <= '0;
        txn_q[c]  <= '0;
        busy_q[c] <= '0;
        last_q[c] <= '0;
        min_q[c]  <= MAXV;
        max_q[c]  <= '0;
        ovl_q[c]  <= '0;
      end
      pend_q   <= '0;
      rdy_q    <= '0;
      busy_any <= 1'b0;
    end else if (!finish) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]  <= st_n[c];
        tmr_q[c] <= tmr_n[c];
        if (acc[c]) txn_q[c] <= sat_inc(txn_q[c]);
        if (acc[c] || st_q[c] != IDLE)
          busy_q[c] <= sat_inc(busy_q[c]);
        if (ovl_inc[c]) ovl_q[c] <= sat_inc(ovl_q[c]);
        if (fin[c]) begin
          last_q[c] <= lat[c];
          if (lat[c] < min_q[c]) min_q[c] <= lat[c];
          if (lat[c] > max_q[c]) max_q[c] <= lat[c];
        end
      end
      pend_q   <= pend_n;
      rdy_q    <= rdy_n;
      busy_any <= any_n;
    end
  end

`ifdef PERF_MON_STALL_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) stall_q[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) stall_q[c] <= '0;
    end else if (!finish) begin
      for (int c = 0; c < NUM_CH; c++)
        if (st_q[c] == DONE_WAIT) stall_q[c] <= sat_inc(stall_q[c]);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (32'(rd_ch) < 32'(NUM_CH)) begin
      case (rd_sel)
        SEL_W'(0): rd_mux = txn_q[rd_ch];
        SEL_W'(1): rd_mux = busy_q[rd_ch];
        SEL_W'(2): rd_mux = last_q[rd_ch];
        SEL_W'(3): rd_mux = min_q[rd_ch];
        SEL_W'(4): rd_mux = max_q[rd_ch];
`ifdef PERF_MON_STALL_EN
        SEL_W'(5): rd_mux = stall_q[rd_ch];
`endif
        SEL_W'(6): rd_mux = ovl_q[rd_ch];
        SEL_W'(7): rd_mux = cnt_t'(st_q[rd_ch]);
        default:   rd_mux = '0;
      endcase
    end
  end

  // reads sample pre-edge state, so a coincident clear does not hide it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_hls_ctrl_perf_monitor.sv
// tb_hls_ctrl_perf_monitor: directed checks of the ap_ctrl performance monitor.
// Expectations follow PERF_MON_STALL_EN when it is defined for the build.
module tb_hls_ctrl_perf_monitor;

  localparam int NCH = 5;
  localparam int CW  = 8;

`ifdef PERF_MON_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           finish;
  logic           clear;
  logic [NCH-1:0] ch_start;
  logic [NCH-1:0] ch_ready;
  logic [NCH-1:0] ch_done;
  logic [NCH-1:0] ch_continue;
  logic           rd_en;
  logic [2:0]     rd_ch;
  logic [2:0]     rd_sel;
  logic [CW-1:0]  rd_data;
  logic           rd_valid;
  logic           busy_any;

  int n_chk  = 0;
  int n_fail = 0;

  hls_ctrl_perf_monitor #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .SEL_W (3)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .finish     (finish),
    .clear      (clear),
    .ch_start   (ch_start),
    .ch_ready   (ch_ready),
    .ch_done    (ch_done),
    .ch_continue(ch_continue),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy_any   (busy_any)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input string tag, input int ch, input int sel,
                    input int exp);
    rd_en  = 1'b1;
    rd_ch  = 3'(ch);
    rd_sel = 3'(sel);
    cyc(1);
    rd_en = 1'b0;
    check({tag, "_v"}, 32'(rd_valid), 1);
    check(tag, 32'(rd_data), exp);
  endtask

  initial begin
    reset       = 1'b0;
    finish      = 1'b0;
    clear       = 1'b0;
    ch_start    = '0;
    ch_ready    = '0;
    ch_done     = '0;
    ch_continue = '1;
    rd_en       = 1'b0;
    rd_ch       = '0;
    rd_sel      = '0;
    cyc(3);
    check("rst_busy_any", 32'(busy_any), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b1;
    cyc(2);
    rd("rst_txn0", 0, 0, 0);
    rd("rst_min0", 0, 3, 255);

    // single ch0 transaction, latency 8
    ch_start[0] = 1'b1;
    cyc(1);
    ch_start[0] = 1'b0;
    check("t1_busy_any", 32'(busy_any), 1);
    cyc(6);
    ch_done[0] = 1'b1;
    cyc(1);
    ch_done[0] = 1'b0;
    check("t1_idle_any", 32'(busy_any), 0);
    rd("t1_txn", 0, 0, 1);
    rd("t1_busy", 0, 1, 8);
    rd("t1_last", 0, 2, 8);
    rd("t1_min", 0, 3, 8);
    rd("t1_max", 0, 4, 8);
    rd("t1_state", 0, 7, 0);

    // ch1: latencies 4, 9, 6 with restart on the done cycle
    ch_start[1] = 1'b1;
    cyc(1);
    ch_start[1] = 1'b0;
    cyc(2);
    ch_done[1]  = 1'b1;
    ch_start[1] = 1'b1;
    cyc(1);
    ch_done[1]  = 1'b0;
    ch_start[1] = 1'b0;
    check("t2_restart_any", 32'(busy_any), 1);
    cyc(7);
    ch_done[1]  = 1'b1;
    ch_start[1] = 1'b1;
    cyc(1);
    ch_done[1]  = 1'b0;
    ch_start[1] = 1'b0;
    cyc(4);
    ch_done[1] = 1'b1;
    cyc(1);
    ch_done[1] = 1'b0;
    rd("t2_txn", 1, 0, 3);
    rd("t2_last", 1, 2, 6);
    rd("t2_busy", 1, 1, 17);
    rd("t2_ovl", 1, 6, 0);
    rd_en  = 1'b1;
    rd_ch  = 3'd1;
    rd_sel = 3'd3;
    cyc(1);
    check("t2_min", 32'(rd_data), 4);
    rd_sel = 3'd4;
    cyc(1);
    rd_en = 1'b0;
    check("t2_max_v", 32'(rd_valid), 1);
    check("t2_max", 32'(rd_data), 9);

    // ch2: re-start accepted only after ready, oldest latency 6 then 4
    ch_start[2] = 1'b1;
    cyc(1);
    cyc(1);
    ch_start[2] = 1'b0;
    ch_ready[2] = 1'b1;
    cyc(1);
    ch_ready[2] = 1'b0;
    ch_start[2] = 1'b1;
    cyc(1);
    ch_start[2] = 1'b0;
    cyc(1);
    ch_done[2] = 1'b1;
    cyc(1);
    ch_done[2] = 1'b0;
    check("t3_still_busy", 32'(busy_any), 1);
    cyc(2);
    ch_done[2] = 1'b1;
    cyc(1);
    ch_done[2] = 1'b0;
    rd("t3_txn", 2, 0, 2);
    rd("t3_ovl", 2, 6, 1);
    rd("t3_max", 2, 4, 6);
    rd("t3_last", 2, 2, 4);
    rd("t3_busy", 2, 1, 9);

    // ch0: done with continue held low for four cycles
    ch_start[0] = 1'b1;
    cyc(1);
    ch_start[0] = 1'b0;
    cyc(2);
    ch_done[0]     = 1'b1;
    ch_continue[0] = 1'b0;
    cyc(1);
    ch_done[0] = 1'b0;
    rd("t4_state_wait", 0, 7, STALL ? 2 : 0);
    cyc(2);
    ch_continue[0] = 1'b1;
    cyc(1);
    rd("t4_stall", 0, 5, STALL ? 4 : 0);
    rd("t4_state_end", 0, 7, 0);
    rd("t4_last", 0, 2, 4);
    rd("t4_txn", 0, 0, 2);
    rd("t4_busy", 0, 1, STALL ? 16 : 12);
    rd("t4_min", 0, 3, 4);

    // ch3 busy for 300 cycles saturates at 255
    ch_start[3] = 1'b1;
    cyc(1);
    ch_start[3] = 1'b0;
    cyc(299);
    rd("t5_busy_sat", 3, 1, 255);
    finish      = 1'b1;
    ch_done[3]  = 1'b1;
    ch_start[4] = 1'b1;
    cyc(2);
    ch_done[3]  = 1'b0;
    ch_start[4] = 1'b0;
    rd("t5_fin_state", 3, 7, 1);
    rd("t5_fin_txn4", 4, 0, 0);
    finish = 1'b0;
    ch_done[3] = 1'b1;
    cyc(1);
    ch_done[3] = 1'b0;
    rd("t5_last_sat", 3, 2, 255);
    rd("t5_txn", 3, 0, 1);
    rd("t5_busy_hold", 3, 1, 255);

    // reset mid-transaction, then clear+done, then out-of-range read
    ch_start[0] = 1'b1;
    cyc(1);
    ch_start[0] = 1'b0;
    cyc(1);
    reset = 1'b0;
    #2;
    check("t6_rst_any", 32'(busy_any), 0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    rd("t6_txn0", 0, 0, 0);
    rd("t6_min0", 0, 3, 255);
    rd("t6_busy3", 3, 1, 0);
    ch_start[1] = 1'b1;
    cyc(1);
    ch_start[1] = 1'b0;
    cyc(1);
    clear      = 1'b1;
    ch_done[1] = 1'b1;
    rd("t6_pre_clear", 1, 0, 1);
    clear      = 1'b0;
    ch_done[1] = 1'b0;
    rd("t6_clr_txn", 1, 0, 0);
    rd("t6_clr_last", 1, 2, 0);
    rd("t6_clr_min", 1, 3, 255);
    check("t6_clr_any", 32'(busy_any), 0);
    cyc(1);
    check("t6_pulse", 32'(rd_valid), 0);
    rd_en  = 1'b1;
    rd_ch  = 3'd5;
    rd_sel = 3'd3;
    #1;
    check("t6_pre_valid", 32'(rd_valid), 0);
    cyc(1);
    rd_en = 1'b0;
    check("t6_oor_valid", 32'(rd_valid), 1);
    check("t6_oor_data", 32'(rd_data), 0);
    cyc(1);
    check("t6_oor_pulse", 32'(rd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
